// File: rtl/iq_phase_rotator.sv
// Three-stage complex phase rotator: register, multiply, sum/rescale/saturate.
// Define ROT_ROUND_EN for round-half-up on the dropped LSBs; otherwise truncate (floor).
module iq_phase_rotator #(
    parameter int NB_DATA   = 8,
    parameter int NBF_DATA  = 6,
    parameter int NB_COEFF  = 8,
    parameter int NBF_COEFF = 6,
    parameter int NB_OUT    = 8,
    parameter int NBF_OUT   = 6,
    parameter int NB_CNT    = 16
) (
    input  logic                       clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_valid,
    input  logic                       i_conj,
    input  logic signed [NB_DATA-1:0]  i_dataI,
    input  logic signed [NB_DATA-1:0]  i_dataQ,
    input  logic signed [NB_COEFF-1:0] i_dataCos,
    input  logic signed [NB_COEFF-1:0] i_dataSin,
    input  logic                       i_clr_sat,
    output logic                       o_valid,
    output logic signed [NB_OUT-1:0]   o_dataRotatedI,
    output logic signed [NB_OUT-1:0]   o_dataRotatedQ,
    output logic                       o_sat,
    output logic                       o_sat_sticky,
    output logic [NB_CNT-1:0]          o_sat_cnt
);

    localparam int NP = NB_DATA + NB_COEFF;
    localparam int SW = NP + 1;
    localparam int RW = SW + 1;
    localparam int D  = NBF_DATA + NBF_COEFF - NBF_OUT;

    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (NB_OUT - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;
`ifdef ROT_ROUND_EN
    localparam logic signed [RW-1:0] RND = RW'((64'd1 << D) >> 1);
`endif

    logic signed [NB_DATA-1:0]  s1_i, s1_q;
    logic signed [NB_COEFF-1:0] s1_cos, s1_sin;
    logic                       s1_conj, s1_valid;

    logic signed [NP-1:0] s2_ic, s2_qs, s2_is, s2_qc;
    logic                 s2_conj, s2_valid;

    logic signed [SW-1:0]     sum_i, sum_q;
    logic signed [RW-1:0]     sh_i, sh_q;
    logic                     sat_i, sat_q, sat_evt;
    logic signed [NB_OUT-1:0] res_i, res_q;

    // Extra guard bit keeps the rounding add from wrapping before the shift.
    function automatic logic signed [RW-1:0] rescale(input logic signed [SW-1:0] s);
        logic signed [RW-1:0] ext;
        ext = RW'(s);
`ifdef ROT_ROUND_EN
        ext = ext + RND;
`endif
        return ext >>> D;
    endfunction

    always_comb begin
        sum_i = '0;
        sum_q = '0;
        if (s2_conj) begin
            sum_i = SW'(s2_ic) + SW'(s2_qs);
            sum_q = SW'(s2_qc) - SW'(s2_is);
        end else begin
            sum_i = SW'(s2_ic) - SW'(s2_qs);
            sum_q = SW'(s2_is) + SW'(s2_qc);
        end
        sh_i = rescale(sum_i);
        sh_q = rescale(sum_q);

        sat_i = (sh_i > SAT_MAX) || (sh_i < SAT_MIN);
        sat_q = (sh_q > SAT_MAX) || (sh_q < SAT_MIN);

        res_i = sh_i[NB_OUT-1:0];
        if (sh_i > SAT_MAX)      res_i = NB_OUT'(SAT_MAX);
        else if (sh_i < SAT_MIN) res_i = NB_OUT'(SAT_MIN);

        res_q = sh_q[NB_OUT-1:0];
        if (sh_q > SAT_MAX)      res_q = NB_OUT'(SAT_MAX);
        else if (sh_q < SAT_MIN) res_q = NB_OUT'(SAT_MIN);

        sat_evt = s2_valid && (sat_i || sat_q);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            s1_i           <= '0;
            s1_q           <= '0;
            s1_cos         <= '0;
            s1_sin         <= '0;
            s1_conj        <= 1'b0;
            s1_valid       <= 1'b0;
            s2_ic          <= '0;
            s2_qs          <= '0;
            s2_is          <= '0;
            s2_qc          <= '0;
            s2_conj        <= 1'b0;
            s2_valid       <= 1'b0;
            o_valid        <= 1'b0;
            o_dataRotatedI <= '0;
            o_dataRotatedQ <= '0;
            o_sat          <= 1'b0;
            o_sat_sticky   <= 1'b0;
            o_sat_cnt      <= '0;
        end else if (i_enable) begin
            s1_i     <= i_dataI;
            s1_q     <= i_dataQ;
            s1_cos   <= i_dataCos;
            s1_sin   <= i_dataSin;
            s1_conj  <= i_conj;
            s1_valid <= i_valid;

            s2_ic    <= NP'(s1_i) * NP'(s1_cos);
            s2_qs    <= NP'(s1_q) * NP'(s1_sin);
            s2_is    <= NP'(s1_i) * NP'(s1_sin);
            s2_qc    <= NP'(s1_q) * NP'(s1_cos);
            s2_conj  <= s1_conj;
            s2_valid <= s1_valid;

            o_valid        <= s2_valid;
            o_dataRotatedI <= res_i;
            o_dataRotatedQ <= res_q;
            o_sat          <= sat_evt;

            // Counter and sticky move together with the clipped sample reaching the output.
            if (i_clr_sat) begin
                o_sat_sticky <= 1'b0;
                o_sat_cnt    <= '0;
            end else if (sat_evt) begin
                o_sat_sticky <= 1'b1;
                if (o_sat_cnt != '1) o_sat_cnt <= o_sat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iq_phase_rotator.sv
// Directed self-checking bench for iq_phase_rotator (default 8/6 formats).
module tb_iq_phase_rotator;

    logic              clock = 1'b0;
    logic              i_reset, i_enable, i_valid, i_conj, i_clr_sat;
    logic signed [7:0] i_dataI, i_dataQ, i_dataCos, i_dataSin;
    logic              o_valid, o_sat, o_sat_sticky;
    logic signed [7:0] o_dataRotatedI, o_dataRotatedQ;
    logic [15:0]       o_sat_cnt;

    int npass = 0;
    int nchk  = 0;

    iq_phase_rotator dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .i_conj         (i_conj),
        .i_dataI        (i_dataI),
        .i_dataQ        (i_dataQ),
        .i_dataCos      (i_dataCos),
        .i_dataSin      (i_dataSin),
        .i_clr_sat      (i_clr_sat),
        .o_valid        (o_valid),
        .o_dataRotatedI (o_dataRotatedI),
        .o_dataRotatedQ (o_dataRotatedQ),
        .o_sat          (o_sat),
        .o_sat_sticky   (o_sat_sticky),
        .o_sat_cnt      (o_sat_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input int di, input int dq, input int dc, input int ds, input logic cj);
        i_dataI   = 8'(di);
        i_dataQ   = 8'(dq);
        i_dataCos = 8'(dc);
        i_dataSin = 8'(ds);
        i_conj    = cj;
    endtask

    // One valid sample, then wait until it should be at the output.
    task automatic run1(input int di, input int dq, input int dc, input int ds, input logic cj);
        drive(di, dq, dc, ds, cj);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("early_valid", o_valid, 0);
        tick();
    endtask

    int idx;
    logic en;
    logic [31:0] snap;
    int got[$];

    initial begin
        i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_clr_sat = 1'b0;
        drive(0, 0, 0, 0, 1'b0);
        tick(); tick();
        chk("rst_valid",  o_valid, 0);
        chk("rst_i",      $signed(o_dataRotatedI), 0);
        chk("rst_q",      $signed(o_dataRotatedQ), 0);
        chk("rst_sat",    o_sat, 0);
        chk("rst_sticky", o_sat_sticky, 0);
        chk("rst_cnt",    o_sat_cnt, 0);
        i_reset = 1'b0;

        run1(32, -16, 64, 0, 1'b0);
        chk("id_valid", o_valid, 1);
        chk("id_i",     $signed(o_dataRotatedI), 32);
        chk("id_q",     $signed(o_dataRotatedQ), -16);
        chk("id_sat",   o_sat, 0);
        tick();
        chk("id_valid_drop", o_valid, 0);

        run1(64, 0, 0, 64, 1'b0);
        chk("rot90_i", $signed(o_dataRotatedI), 0);
        chk("rot90_q", $signed(o_dataRotatedQ), 64);
        run1(64, 0, 0, 64, 1'b1);
        chk("conj_i", $signed(o_dataRotatedI), 0);
        chk("conj_q", $signed(o_dataRotatedQ), -64);

        run1(127, 127, 127, 127, 1'b0);
        chk("clipp_i",      $signed(o_dataRotatedI), 0);
        chk("clipp_q",      $signed(o_dataRotatedQ), 127);
        chk("clipp_sat",    o_sat, 1);
        chk("clipp_sticky", o_sat_sticky, 1);
        chk("clipp_cnt",    o_sat_cnt, 1);
        run1(-128, 127, 127, 127, 1'b0);
        chk("clipn_i",   $signed(o_dataRotatedI), -128);
        chk("clipn_q",   $signed(o_dataRotatedQ), -2);
        chk("clipn_sat", o_sat, 1);
        chk("clipn_cnt", o_sat_cnt, 2);
        tick();
        chk("sat_drop", o_sat, 0);
        chk("cnt_hold", o_sat_cnt, 2);

`ifdef ROT_ROUND_EN
        run1(1, 0, 32, 0, 1'b0);
        chk("rnd_pos", $signed(o_dataRotatedI), 1);
        run1(-1, 0, 32, 0, 1'b0);
        chk("rnd_neg", $signed(o_dataRotatedI), 0);
`else
        run1(1, 0, 32, 0, 1'b0);
        chk("rnd_pos", $signed(o_dataRotatedI), 0);
        run1(-1, 0, 32, 0, 1'b0);
        chk("rnd_neg", $signed(o_dataRotatedI), -1);
`endif

        // Stall: five samples, enable dropped for four cycles while two are in flight.
        idx = 0;
        for (int step = 0; step < 14; step++) begin
            en = (step < 2) || (step > 5);
            i_enable = en;
            if (idx < 5) begin
                i_valid = 1'b1;
                drive(10 * (idx + 1), 0, 64, 0, 1'b0);
            end else begin
                i_valid = 1'b0;
            end
            snap = {7'd0, o_valid, o_dataRotatedI, o_dataRotatedQ, o_sat_cnt[7:0]};
            tick();
            if (en) begin
                if (idx < 5) idx++;
                if (o_valid) got.push_back(int'($signed(o_dataRotatedI)));
            end else begin
                chk("stall_frozen", {7'd0, o_valid, o_dataRotatedI, o_dataRotatedQ, o_sat_cnt[7:0]}, snap);
            end
        end
        i_enable = 1'b1;
        i_valid  = 1'b0;
        chk("stall_count", got.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < got.size()) chk("stall_order", got[k], 10 * (k + 1));
        end

        // Reset with two samples in flight.
        i_valid = 1'b1;
        drive(64, 32, 64, 0, 1'b0);
        tick();
        drive(32, 16, 64, 0, 1'b0);
        tick();
        i_reset = 1'b1;
        tick();
        chk("mid_rst_valid",  o_valid, 0);
        chk("mid_rst_i",      $signed(o_dataRotatedI), 0);
        chk("mid_rst_q",      $signed(o_dataRotatedQ), 0);
        chk("mid_rst_sticky", o_sat_sticky, 0);
        chk("mid_rst_cnt",    o_sat_cnt, 0);
        i_reset = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_ghost", o_valid, 0);
        end
        run1(32, -16, 64, 0, 1'b0);
        chk("post_rst_valid", o_valid, 1);
        chk("post_rst_i",     $signed(o_dataRotatedI), 32);

        // Clear coincident with a clip: clear wins.
        run1(127, 127, 127, 127, 1'b0);
        chk("pre_clr_cnt", o_sat_cnt, 1);
        drive(127, 127, 127, 127, 1'b0);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        i_clr_sat = 1'b1;
        tick();
        i_clr_sat = 1'b0;
        chk("clr_sat",    o_sat, 1);
        chk("clr_sticky", o_sat_sticky, 0);
        chk("clr_cnt",    o_sat_cnt, 0);
        tick();
        chk("clr_hold_cnt", o_sat_cnt, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
